// File: rtl/mereshf_top.sv
// mereshf_top: one 8N1 UART character per push of btn1.
// The character is ASCII '0'..'7', selected by {sw8, sw5, sw4} when the press is seen.
// btn1 is synchronised and edge-detected. The character then goes through a
// START/DATA/STOP transmit FSM, which is paced by a baud divider.
// txd and rts are driven straight from flops, so they cannot glitch.
module mereshf_top #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic btn1,
    input  logic sw4,
    input  logic sw5,
    input  logic sw8,
    output logic rts,
    output logic txd
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_START = 2'd1;
    localparam logic [1:0]  ST_DATA  = 2'd2;
    localparam logic [1:0]  ST_STOP  = 2'd3;
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  ASCII_0  = 8'h30;

    logic        b1_r;
    logic        b2_r;
    logic        b3_r;
    logic        press_s;
    logic        bit_done_s;
    logic [2:0]  next_idx_s;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_nxt_s;
    logic [7:0]  data_r;
    logic [7:0]  data_nxt_s;
    logic        txd_r;
    logic        txd_nxt_s;
    logic        rts_r;
    logic        rts_nxt_s;

    // Two-flop synchroniser for btn1 plus a history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b1_r <= 1'b0;
            b2_r <= 1'b0;
            b3_r <= 1'b0;
        end else begin
            b1_r <= btn1;
            b2_r <= b1_r;
            b3_r <= b2_r;
        end
    end

    // A held button yields a single one-cycle pulse on its rising edge
    assign press_s    = b2_r & ~b3_r;
    assign bit_done_s = (cnt_r == LAST_CNT);
    assign next_idx_s = bit_idx_r + 3'd1;

    // Next-state and next-output logic of the transmit FSM
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        data_nxt_s    = data_r;
        txd_nxt_s     = txd_r;
        rts_nxt_s     = rts_r;
        case (state_r)
            ST_IDLE: begin
                // Presses are only honoured here. Any press while busy is dropped, not queued.
                if (press_s) begin
                    state_nxt_s   = ST_START;
                    cnt_nxt_s     = 16'd0;
                    bit_idx_nxt_s = 3'd0;
                    data_nxt_s    = ASCII_0 + {5'b00000, sw8, sw5, sw4};
                    txd_nxt_s     = 1'b0;
                    rts_nxt_s     = 1'b1;
                end else begin
                    cnt_nxt_s = 16'd0;
                    txd_nxt_s = 1'b1;
                    rts_nxt_s = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_nxt_s = ST_DATA;
                    cnt_nxt_s   = 16'd0;
                    txd_nxt_s   = data_r[0];
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                    txd_nxt_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    cnt_nxt_s = 16'd0;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                        txd_nxt_s   = 1'b1;
                    end else begin
                        bit_idx_nxt_s = next_idx_s;
                        txd_nxt_s     = data_r[next_idx_s];
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 16'd0;
                    txd_nxt_s   = 1'b1;
                    rts_nxt_s   = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                    txd_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                cnt_nxt_s     = 16'd0;
                bit_idx_nxt_s = 3'd0;
                txd_nxt_s     = 1'b1;
                rts_nxt_s     = 1'b0;
            end
        endcase
    end

    // FSM, divider and output registers; reset aborts any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            data_r    <= 8'h00;
            txd_r     <= 1'b1;
            rts_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            data_r    <= data_nxt_s;
            txd_r     <= txd_nxt_s;
            rts_r     <= rts_nxt_s;
        end
    end

    assign txd = txd_r;
    assign rts = rts_r;

endmodule

// File: tb/tb_mereshf_top.sv
// tb_mereshf_top: scoreboard bench for mereshf_top running at CLKS_PER_BIT=4.
// A monitor decodes each frame on txd and compares it with the queue of
// expected characters that the scenario tasks push when they press btn1.
module tb_mereshf_top;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    logic btn1;
    logic sw4;
    logic sw5;
    logic sw8;
    logic rts;
    logic txd;

    int         checks      = 0;
    int         failures    = 0;
    int         frames_seen = 0;
    logic [7:0] exp_q[$];

    mereshf_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .btn1(btn1),
        .sw4 (sw4),
        .sw5 (sw5),
        .sw8 (sw8),
        .rts (rts),
        .txd (txd)
    );

    always #5 clk = ~clk;

    // Frame monitor: samples each bit mid-way and checks the exact frame length.
    // A frame interrupted by reset is discarded without popping the queue.
    initial begin : monitor
        logic [9:0] bits;
        logic       aborted;
        logic       rts_ok;
        logic       rts_last;
        logic [7:0] exp_b;
        forever begin
            @(posedge clk); #1;
            if (rst === 1'b0 && txd === 1'b0) begin
                aborted  = 1'b0;
                rts_ok   = 1'b1;
                rts_last = 1'b0;
                bits     = 10'd0;
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) begin
                        @(posedge clk); #1;
                    end
                    if (rst !== 1'b0) aborted = 1'b1;
                    if (rts !== 1'b1) rts_ok = 1'b0;
                    if ((c % CPB) == (CPB / 2)) bits[c / CPB] = txd;
                    if (c == FRAME - 1) rts_last = rts;
                end
                if (!aborted) begin
                    @(posedge clk); #1;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_frame got=%02h required=no frame", bits[8:1]);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (bits[8:1] !== exp_b) begin
                            failures++;
                            $display("FAIL frame_data got=%02h required=%02h", bits[8:1], exp_b);
                        end
                    end
                    checks++;
                    if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || rts_ok !== 1'b1) begin
                        failures++;
                        $display("FAIL framing start=%b stop=%b rts_ok=%b required 0 1 1",
                                 bits[0], bits[9], rts_ok);
                    end
                    checks++;
                    if (rts_last !== 1'b1 || rts !== 1'b0 || txd !== 1'b1) begin
                        failures++;
                        $display("FAIL frame_length rts_last=%b rts_after=%b txd_after=%b required 1 0 1",
                                 rts_last, rts, txd);
                    end
                    frames_seen++;
                end
            end
        end
    end

    task automatic set_sw(input logic [2:0] v);
        {sw8, sw5, sw4} = v;
    endtask

    task automatic pulse_btn(input int hold);
        @(negedge clk);
        btn1 = 1'b1;
        repeat (hold) @(negedge clk);
        btn1 = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        btn1 = 1'b0;
        set_sw(3'b000);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b1 || rts !== 1'b0) begin
            failures++;
            $display("FAIL reset_during txd=%b rts=%b required 1 0", txd, rts);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b1 || rts !== 1'b0) begin
            failures++;
            $display("FAIL reset_after txd=%b rts=%b required 1 0", txd, rts);
        end
    endtask

    task automatic test_char0();
        int target;
        target = frames_seen + 1;
        set_sw(3'b000);
        @(negedge clk);
        btn1 = 1'b1;
        exp_q.push_back(8'h30);
        @(posedge clk);          // E0
        @(posedge clk);          // E1
        #1;
        checks++;
        if (txd !== 1'b1 || rts !== 1'b0) begin
            failures++;
            $display("FAIL press_latency_e1 txd=%b rts=%b required 1 0", txd, rts);
        end
        @(posedge clk);          // E2
        #1;
        checks++;
        if (txd !== 1'b0 || rts !== 1'b1) begin
            failures++;
            $display("FAIL press_latency_e2 txd=%b rts=%b required 0 1", txd, rts);
        end
        repeat (7) @(negedge clk);
        btn1 = 1'b0;
        for (int i = 0; i < 3 * FRAME && frames_seen < target; i++) @(posedge clk);
        #2;
        checks++;
        if (frames_seen !== target || rts !== 1'b0 || txd !== 1'b1) begin
            failures++;
            $display("FAIL char0_done frames=%0d rts=%b txd=%b required %0d 0 1",
                     frames_seen, rts, txd, target);
        end
    endtask

    task automatic test_char5();
        int target;
        target = frames_seen + 1;
        set_sw(3'b101);
        exp_q.push_back(8'h35);
        pulse_btn(3);
        for (int i = 0; i < 3 * FRAME && frames_seen < target; i++) @(posedge clk);
        #2;
        checks++;
        if (frames_seen !== target) begin
            failures++;
            $display("FAIL char5_done frames=%0d required %0d", frames_seen, target);
        end
    endtask

    task automatic test_mid_frame_press();
        int target;
        target = frames_seen + 1;
        set_sw(3'b010);
        exp_q.push_back(8'h32);
        pulse_btn(3);
        repeat (8) @(posedge clk);
        set_sw(3'b101);          // must not disturb the frame in flight
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (rts !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid_frame rts=%b required 1", rts);
        end
        pulse_btn(3);
        for (int i = 0; i < 3 * FRAME && frames_seen < target; i++) @(posedge clk);
        repeat (2 * FRAME) @(posedge clk);
        #2;
        checks++;
        if (frames_seen !== target || rts !== 1'b0) begin
            failures++;
            $display("FAIL no_queued_frame frames=%0d rts=%b required %0d 0", frames_seen, rts, target);
        end
        set_sw(3'b010);
        target = target + 1;
        exp_q.push_back(8'h32);
        pulse_btn(3);
        for (int i = 0; i < 3 * FRAME && frames_seen < target; i++) @(posedge clk);
        #2;
        checks++;
        if (frames_seen !== target) begin
            failures++;
            $display("FAIL frame_after_idle frames=%0d required %0d", frames_seen, target);
        end
    endtask

    task automatic test_back_to_back();
        int target;
        set_sw(3'b111);
        repeat (4) @(posedge clk);
        // Press whose pulse lands on the STOP->IDLE edge: must be ignored
        target = frames_seen + 1;
        exp_q.push_back(8'h37);
        @(negedge clk);
        btn1 = 1'b1;
        repeat (3) @(posedge clk);       // c0: start bit begins
        @(negedge clk);
        btn1 = 1'b0;
        repeat (FRAME - 3) @(posedge clk);
        @(negedge clk);
        btn1 = 1'b1;
        repeat (3) @(posedge clk);       // lands on c0+FRAME
        #1;
        checks++;
        if (rts !== 1'b0 || txd !== 1'b1) begin
            failures++;
            $display("FAIL press_on_stop_exit rts=%b txd=%b required 0 1", rts, txd);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rts !== 1'b0 || frames_seen !== target) begin
            failures++;
            $display("FAIL stop_exit_ignored rts=%b frames=%0d required 0 %0d", rts, frames_seen, target);
        end
        @(negedge clk);
        btn1 = 1'b0;
        repeat (4) @(posedge clk);
        // Press accepted exactly one cycle after rts falls
        target = frames_seen + 2;
        exp_q.push_back(8'h37);
        @(negedge clk);
        btn1 = 1'b1;
        repeat (3) @(posedge clk);       // c0
        @(negedge clk);
        btn1 = 1'b0;
        repeat (FRAME - 2) @(posedge clk);
        @(negedge clk);
        btn1 = 1'b1;
        exp_q.push_back(8'h37);
        repeat (2) @(posedge clk);       // c0+FRAME: rts falls
        #1;
        checks++;
        if (rts !== 1'b0) begin
            failures++;
            $display("FAIL rts_fall rts=%b required 0", rts);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rts !== 1'b1 || txd !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept rts=%b txd=%b required 1 0", rts, txd);
        end
        @(negedge clk);
        btn1 = 1'b0;
        for (int i = 0; i < 3 * FRAME && frames_seen < target; i++) @(posedge clk);
        #2;
        checks++;
        if (frames_seen !== target) begin
            failures++;
            $display("FAIL b2b_frames frames=%0d required %0d", frames_seen, target);
        end
    endtask

    task automatic test_reset_mid_data();
        int fs0;
        fs0 = frames_seen;
        set_sw(3'b000);
        @(negedge clk);
        btn1 = 1'b1;
        repeat (3) @(posedge clk);       // c0
        @(negedge clk);
        btn1 = 1'b0;
        repeat (CPB + 3) @(posedge clk); // inside data bit 0 (txd low)
        #1;
        checks++;
        if (rts !== 1'b1 || txd !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_busy rts=%b txd=%b required 1 0", rts, txd);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || rts !== 1'b0) begin
            failures++;
            $display("FAIL async_reset txd=%b rts=%b required 1 0", txd, rts);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * FRAME) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b1 || rts !== 1'b0 || frames_seen !== fs0) begin
            failures++;
            $display("FAIL idle_after_reset txd=%b rts=%b frames=%0d required 1 0 %0d",
                     txd, rts, frames_seen, fs0);
        end
    endtask

    task automatic test_held_button();
        int target;
        target = frames_seen + 1;
        set_sw(3'b011);
        exp_q.push_back(8'h33);
        @(negedge clk);
        btn1 = 1'b1;
        repeat (3 * FRAME) @(posedge clk);
        #1;
        checks++;
        if (frames_seen !== target || rts !== 1'b0) begin
            failures++;
            $display("FAIL held_one_frame frames=%0d rts=%b required %0d 0", frames_seen, rts, target);
        end
        @(negedge clk);
        btn1 = 1'b0;
        repeat (FRAME) @(posedge clk);
        #1;
        checks++;
        if (frames_seen !== target) begin
            failures++;
            $display("FAIL held_release frames=%0d required %0d", frames_seen, target);
        end
    endtask

    initial begin
        test_reset();
        test_char0();
        test_char5();
        test_mid_frame_press();
        test_back_to_back();
        test_reset_mid_data();
        test_held_button();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
